// File: rtl/imm_decode_stage.sv
// Decode stage: opcode -> immctrl decode, immediate generation and a 2-entry
// skid buffer toward EX, with flush and a saturating illegal-opcode counter.

module ImmGen #(
  parameter int WORD_LEN = 32
) (
  input  logic [31:7]         i_instr,
  input  logic [4:0]          i_immctrl,
  output logic [WORD_LEN-1:0] o_immout
);

  logic [31:0] w_imm32;

  // immctrl is one-hot: I, S, B, U, J from bit 0 upward; anything else yields zero.
  always_comb begin
    w_imm32 = '0;
    case (i_immctrl)
      5'b00001: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      5'b00010: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      5'b00100: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
      5'b01000: w_imm32 = {i_instr[31:12], 12'b0};
      5'b10000: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
      default:  w_imm32 = '0;
    endcase
  end

  assign o_immout = WORD_LEN'($signed(w_imm32));

endmodule

module imm_decode_stage #(
  parameter int WORD_LEN  = 32,
  parameter int ADDR_SIZE = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [31:0]          i_in_instr,
  input  logic [ADDR_SIZE-1:0] i_in_pc,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [31:0]          o_out_instr,
  output logic [ADDR_SIZE-1:0] o_out_pc,
  output logic [4:0]           o_out_immctrl,
  output logic [WORD_LEN-1:0]  o_out_imm,
  output logic                 o_out_illegal,
  output logic [CNT_W-1:0]     o_illegal_cnt
);

  localparam logic [4:0] IMM_NONE = 5'b00000;
  localparam logic [4:0] IMM_I    = 5'b00001;
  localparam logic [4:0] IMM_S    = 5'b00010;
  localparam logic [4:0] IMM_B    = 5'b00100;
  localparam logic [4:0] IMM_U    = 5'b01000;
  localparam logic [4:0] IMM_J    = 5'b10000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]          instr;
    logic [ADDR_SIZE-1:0] pc;
    logic [4:0]           immctrl;
    logic [WORD_LEN-1:0]  imm;
    logic                 illegal;
  } entry_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_in_ready;
  entry_t           r_head;
  entry_t           r_skid;
  entry_t           w_in_entry;
  logic [CNT_W-1:0] r_illegal_cnt;
  logic [4:0]       w_immctrl;
  logic             w_illegal;
  logic [WORD_LEN-1:0] w_imm;
  logic             w_enq;
  logic             w_deq;
  logic             w_load_head_in;
  logic             w_load_head_skid;
  logic             w_load_skid;

  // Only fully-formed 32-bit opcodes ([1:0] == 2'b11) are ever matched.
  always_comb begin
    w_immctrl = IMM_NONE;
    w_illegal = 1'b0;
    case (i_in_instr[6:0])
      7'b0110111, 7'b0010111:                     w_immctrl = IMM_U;
      7'b1101111:                                 w_immctrl = IMM_J;
      7'b1100111, 7'b0000011, 7'b0010011,
      7'b1110011, 7'b0001111:                     w_immctrl = IMM_I;
      7'b0100011:                                 w_immctrl = IMM_S;
      7'b1100011:                                 w_immctrl = IMM_B;
      7'b0110011:                                 w_immctrl = IMM_NONE;
      default:                                    w_illegal = 1'b1;
    endcase
  end

  ImmGen #(.WORD_LEN(WORD_LEN)) u_immgen (
    .i_instr  (i_in_instr[31:7]),
    .i_immctrl(w_immctrl),
    .o_immout (w_imm)
  );

  assign w_in_entry = '{instr: i_in_instr, pc: i_in_pc, immctrl: w_immctrl,
                        imm: w_imm, illegal: w_illegal};

  assign o_out_valid = (r_state != EMPTY);
  assign o_in_ready  = r_in_ready;
  assign w_enq       = i_in_valid & r_in_ready & ~i_flush;
  assign w_deq       = o_out_valid & i_out_ready;

  always_comb begin
    w_next_state     = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (i_flush) begin
      w_next_state = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_enq) begin
            w_next_state   = ONE;
            w_load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (w_enq && w_deq) begin
            w_load_head_in = 1'b1;
          end else if (w_enq) begin
            w_next_state = TWO;
            w_load_skid  = 1'b1;
          end else if (w_deq) begin
            w_next_state = EMPTY;
          end
        end
        TWO: begin
          if (w_deq) begin
            w_next_state     = ONE;
            w_load_head_skid = 1'b1;
          end
        end
        default: w_next_state = EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state so it never sees out_ready combinationally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
      r_head     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != TWO);
      if (w_load_head_in) begin
        r_head <= w_in_entry;
      end else if (w_load_head_skid) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_entry;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_enq && w_illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
      r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
    end
  end

  assign o_out_instr   = r_head.instr;
  assign o_out_pc      = r_head.pc;
  assign o_out_immctrl = r_head.immctrl;
  assign o_out_imm     = r_head.imm;
  assign o_out_illegal = r_head.illegal;
  assign o_illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode, skid buffering, flush,
// saturating illegal counter (CNT_W=2) and asynchronous reset.

module tb_imm_decode_stage;

  logic        clk;
  logic        rstN;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] inInstr;
  logic [31:0] inPc;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstr;
  logic [31:0] outPc;
  logic [4:0]  outImmctrl;
  logic [31:0] outImm;
  logic        outIllegal;
  logic [1:0]  illegalCnt;

  int checkCount = 0;
  int failCount  = 0;

  imm_decode_stage #(.WORD_LEN(32), .ADDR_SIZE(32), .CNT_W(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_flush      (flush),
    .i_in_valid   (inValid),
    .o_in_ready   (inReady),
    .i_in_instr   (inInstr),
    .i_in_pc      (inPc),
    .o_out_valid  (outValid),
    .i_out_ready  (outReady),
    .o_out_instr  (outInstr),
    .o_out_pc     (outPc),
    .o_out_immctrl(outImmctrl),
    .o_out_imm    (outImm),
    .o_out_illegal(outIllegal),
    .o_illegal_cnt(illegalCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic fl, input logic ordy);
    inValid  = v;
    inInstr  = instr;
    inPc     = pc;
    flush    = fl;
    outReady = ordy;
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vecInstr [4] = '{32'h00112623, 32'hFE000EE3, 32'h123452B7, 32'h008000EF};
  logic [31:0] vecImm   [4] = '{32'h0000000C, 32'hFFFFFFFC, 32'h12345000, 32'h00000008};
  logic [4:0]  vecCtrl  [4] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000};
  logic [1:0]  satCnt   [4] = '{2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("rst_in_ready", 64'(inReady), 64'd0);
    checkOutput("rst_cnt", 64'(illegalCnt), 64'd0);
    checkOutput("rst_imm", 64'(outImm), 64'd0);
    tick();
    tick();
    rstN = 1'b1;
    checkOutput("rel_in_ready_low", 64'(inReady), 64'd0);
    tick();
    checkOutput("rel_in_ready_high", 64'(inReady), 64'd1);

    $display("[TB] single addi");
    applyStimulus(1'b1, 32'hFFF00093, 32'h100, 1'b0, 1'b1);
    tick();
    checkOutput("addi_valid", 64'(outValid), 64'd1);
    checkOutput("addi_ctrl", 64'(outImmctrl), 64'h01);
    checkOutput("addi_imm", 64'(outImm), 64'hFFFFFFFF);
    checkOutput("addi_pc", 64'(outPc), 64'h100);
    checkOutput("addi_illegal", 64'(outIllegal), 64'd0);

    $display("[TB] back-to-back S/B/U/J");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, vecInstr[i], 32'h104 + 32'(4 * i), 1'b0, 1'b1);
      tick();
      checkOutput($sformatf("b2b%0d_valid", i), 64'(outValid), 64'd1);
      checkOutput($sformatf("b2b%0d_imm", i), 64'(outImm), 64'(vecImm[i]));
      checkOutput($sformatf("b2b%0d_ctrl", i), 64'(outImmctrl), 64'(vecCtrl[i]));
      checkOutput($sformatf("b2b%0d_instr", i), 64'(outInstr), 64'(vecInstr[i]));
      checkOutput($sformatf("b2b%0d_ready", i), 64'(inReady), 64'd1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("drain_valid", 64'(outValid), 64'd0);

    $display("[TB] backpressure fill");
    applyStimulus(1'b1, 32'h00112623, 32'h200, 1'b0, 1'b0);
    tick();
    checkOutput("bp1_ready", 64'(inReady), 64'd1);
    applyStimulus(1'b1, 32'h123452B7, 32'h204, 1'b0, 1'b0);
    tick();
    checkOutput("bp2_ready", 64'(inReady), 64'd0);
    checkOutput("bp2_head_pc", 64'(outPc), 64'h200);
    applyStimulus(1'b1, 32'h008000EF, 32'h208, 1'b0, 1'b0);
    tick();
    checkOutput("bp3_ready", 64'(inReady), 64'd0);
    checkOutput("bp3_head_instr", 64'(outInstr), 64'h00112623);
    checkOutput("bp3_head_imm", 64'(outImm), 64'h0000000C);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("bp4_valid", 64'(outValid), 64'd1);
    checkOutput("bp4_head_pc", 64'(outPc), 64'h204);
    checkOutput("bp4_head_imm", 64'(outImm), 64'h12345000);
    checkOutput("bp4_ready", 64'(inReady), 64'd1);
    tick();
    checkOutput("bp5_valid", 64'(outValid), 64'd0);

    $display("[TB] flush while full");
    applyStimulus(1'b1, 32'hFFF00093, 32'h300, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hFE000EE3, 32'h304, 1'b0, 1'b0);
    tick();
    checkOutput("fl_pre_ready", 64'(inReady), 64'd0);
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'h308, 1'b1, 1'b0);
    tick();
    checkOutput("fl_valid", 64'(outValid), 64'd0);
    checkOutput("fl_ready", 64'(inReady), 64'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("fl_dropped", 64'(outValid), 64'd0);
    checkOutput("fl_cnt", 64'(illegalCnt), 64'd0);

    $display("[TB] illegal counter");
    applyStimulus(1'b1, 32'h00000000, 32'h400, 1'b0, 1'b1);
    tick();
    checkOutput("ill_flag", 64'(outIllegal), 64'd1);
    checkOutput("ill_ctrl", 64'(outImmctrl), 64'd0);
    checkOutput("ill_cnt", 64'(illegalCnt), 64'd1);
    applyStimulus(1'b1, 32'h00000033, 32'h404, 1'b0, 1'b1);
    tick();
    checkOutput("add_flag", 64'(outIllegal), 64'd0);
    checkOutput("add_ctrl", 64'(outImmctrl), 64'd0);
    checkOutput("add_imm", 64'(outImm), 64'd0);
    checkOutput("add_cnt", 64'(illegalCnt), 64'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h0000007F, 32'h408 + 32'(4 * i), 1'b0, 1'b1);
      tick();
      checkOutput($sformatf("sat%0d_cnt", i), 64'(illegalCnt), 64'(satCnt[i]));
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();

    $display("[TB] reset while full");
    applyStimulus(1'b1, 32'h00112623, 32'h500, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h123452B7, 32'h504, 1'b0, 1'b0);
    tick();
    checkOutput("rf_pre_valid", 64'(outValid), 64'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rstN = 1'b0;
    #1;
    checkOutput("rf_valid", 64'(outValid), 64'd0);
    checkOutput("rf_cnt", 64'(illegalCnt), 64'd0);
    checkOutput("rf_ready", 64'(inReady), 64'd0);
    checkOutput("rf_pc", 64'(outPc), 64'd0);
    tick();
    rstN = 1'b1;
    checkOutput("rf_rel_ready_low", 64'(inReady), 64'd0);
    tick();
    checkOutput("rf_rel_ready_high", 64'(inReady), 64'd1);
    checkOutput("rf_rel_valid", 64'(outValid), 64'd0);

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
